// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - fetch stage bus bundle: imem handshake, redirect/stall control, IF/ID slot
//
// Purpose: groups every non-clock signal of if_fetch so the stage and its
// environment connect through one port.
//   master : the fetch stage (drives imem_req/imem_addr and the IF/ID slot)
//   slave  : the environment (memory, redirect source, downstream decoder)
// Signals:
//   imem_req/imem_addr         fetch request pulse and word address
//   imem_rvalid/imem_rdata     response strobe and instruction word
//   redirect_valid/redirect_pc branch/jump redirect of the fetch stream
//   stall                      downstream not accepting the held instruction
//   if_valid/if_pc/if_instr    IF/ID slot contents
//   Op/Funct3/Funct7           decoder fields sliced from if_instr

interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc, stall,
    output if_valid, if_pc, if_instr, Op, Funct3, Funct7
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc, stall,
    input  if_valid, if_pc, if_instr, Op, Funct3, Funct7
  );
endinterface

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V instruction fetch stage with single-outstanding imem handshake
//
// Purpose: owns the fetch PC, issues one word fetch at a time, holds the
// returned instruction in the IF/ID slot until downstream consumes it, and
// follows redirects that may arrive in any state (including mid-fetch).
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    if_fetch_if.master (imem request/response, redirect, stall,
//          IF/ID slot and Op/Funct3/Funct7 decoder fields)
// Parameters:
//   RESET_PC   fetch address after reset (word aligned)
//   NOP_INSTR  slot instruction after reset and after a flush

module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       reset,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;

  logic [31:0] w_redir_pc;
  logic        w_redir;
  logic        w_rvalid;

  // Low address bits of the redirect target are forced to zero; masking keeps
  // every bit of the input in use.
  assign w_redir_pc = bus.redirect_pc & ~32'h0000_0003;
  assign w_redir    = bus.redirect_valid;
  assign w_rvalid   = bus.imem_rvalid;

  // Request is suppressed in a redirect cycle so the old-stream address never
  // goes out; the new target is requested the following cycle.
  assign bus.imem_req  = (r_state == S_REQ) && !w_redir;
  assign bus.imem_addr = r_fetch_pc;

  assign bus.if_valid = r_if_valid;
  assign bus.if_pc    = r_if_pc;
  assign bus.if_instr = r_if_instr;
  assign bus.Op       = r_if_instr[6:0];
  assign bus.Funct3   = r_if_instr[14:12];
  assign bus.Funct7   = r_if_instr[31:25];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_redir) begin
            r_fetch_pc <= w_redir_pc;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_rvalid) begin
            if (w_redir) begin
              // Response belongs to the abandoned stream: drop it.
              r_fetch_pc <= w_redir_pc;
              r_state    <= S_REQ;
            end else begin
              r_if_instr <= bus.imem_rdata;
              r_if_pc    <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 32'd4;
              r_if_valid <= 1'b1;
              r_state    <= S_HOLD;
            end
          end else if (w_redir) begin
            // The old request is still in flight; its response must be
            // swallowed before a new request may be issued.
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (w_redir) begin
            r_fetch_pc <= w_redir_pc;
          end
          if (w_rvalid) begin
            r_state <= S_REQ;
          end
        end

        S_HOLD: begin
          if (w_redir) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_REQ;
          end else if (!bus.stall) begin
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
          end
        end

        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch against a transaction-level model

module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  logic rst1;

  if_fetch_if ifc();
  if_fetch_if ifc1();

  if_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk   (clk),
    .reset (rst1),
    .bus   (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // stimulus knobs
  logic        s_redir;
  logic [31:0] s_rpc;
  logic        s_stall;

  // memory model
  int          mem_lat;
  int          mem_cnt;
  logic [31:0] mem_data;
  logic        fixed_en;
  logic [31:0] fixed_data;
  logic        stray_rv;

  // reference model: what the fetch stage has promised so far
  logic [31:0] m_pc;        // next address to fetch
  logic [31:0] m_req_addr;  // address of the outstanding request
  logic        m_pending;   // a request is outstanding
  logic        m_drop;      // outstanding response belongs to a dead stream
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_req_addr = 32'h0;
    m_pending = 1'b0;
    m_drop    = 1'b0;
    m_valid   = 1'b0;
    m_if_pc   = 32'h0;
    m_instr   = NOP;
    mem_cnt   = 0;
  endtask

  // One clock cycle: drive inputs, check the combinational request, advance
  // the model at the edge, then check the registered slot.
  task automatic cycle();
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    rv = 1'b0;
    rd = $urandom;
    if (stray_rv) begin
      rv = 1'b1;
      stray_rv = 1'b0;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_data;
      end
    end
    ifc.imem_rvalid    = rv;
    ifc.imem_rdata     = rd;
    ifc.redirect_valid = s_redir;
    ifc.redirect_pc    = s_rpc;
    ifc.stall          = s_stall;
    exp_req = !m_pending && !m_valid && !s_redir;
    #1;
    chk("imem_req", {31'b0, ifc.imem_req}, {31'b0, exp_req});
    if (exp_req) begin
      chk("imem_addr", ifc.imem_addr, m_pc);
      mem_cnt  = mem_lat;
      mem_data = fixed_en ? fixed_data : $urandom;
    end
    @(posedge clk);
    if (exp_req) begin
      m_pending  = 1'b1;
      m_drop     = 1'b0;
      m_req_addr = m_pc;
    end else if (m_pending) begin
      if (rv) begin
        m_pending = 1'b0;
        if (!m_drop && !s_redir) begin
          m_valid = 1'b1;
          m_instr = rd;
          m_if_pc = m_req_addr;
          m_pc    = m_req_addr + 32'd4;
        end
      end
      if (s_redir) m_drop = 1'b1;
    end else if (m_valid) begin
      if (s_redir) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (!s_stall) begin
        m_valid = 1'b0;
      end
    end
    if (s_redir) m_pc = s_rpc & ~32'h3;
    @(negedge clk);
    chk("if_valid", {31'b0, ifc.if_valid}, {31'b0, m_valid});
    chk("if_pc", ifc.if_pc, m_if_pc);
    chk("if_instr", ifc.if_instr, m_instr);
    chk("Op", {25'b0, ifc.Op}, {25'b0, m_instr[6:0]});
    chk("Funct3", {29'b0, ifc.Funct3}, {29'b0, m_instr[14:12]});
    chk("Funct7", {25'b0, ifc.Funct7}, {25'b0, m_instr[31:25]});
  endtask

  initial begin
    logic [31:0] wrap_q[$];
    logic        r1;
    int          guard;

    reset = 1'b1;
    rst1  = 1'b1;
    s_redir = 1'b0; s_rpc = 32'h0; s_stall = 1'b0;
    mem_lat = 1; fixed_en = 1'b0; fixed_data = 32'h0; stray_rv = 1'b0; mem_data = 32'h0;
    ifc.imem_rvalid = 1'b0; ifc.imem_rdata = 32'h0;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 32'h0; ifc.stall = 1'b0;
    ifc1.imem_rvalid = 1'b0; ifc1.imem_rdata = 32'h0;
    ifc1.redirect_valid = 1'b0; ifc1.redirect_pc = 32'h0; ifc1.stall = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // reset state
    chk("rst_if_valid", {31'b0, ifc.if_valid}, 32'd0);
    chk("rst_Op", {25'b0, ifc.Op}, 32'h13);
    chk("rst_Funct3", {29'b0, ifc.Funct3}, 32'd0);
    chk("rst_Funct7", {25'b0, ifc.Funct7}, 32'd0);
    chk("rst_imem_req", {31'b0, ifc.imem_req}, 32'd1);
    chk("rst_imem_addr", ifc.imem_addr, 32'h0);

    // basic fetch, 1-cycle memory
    mem_lat = 1; fixed_en = 1'b1; fixed_data = 32'h0050_0093;
    cycle();
    cycle();
    chk("f1_if_valid", {31'b0, ifc.if_valid}, 32'd1);
    chk("f1_if_pc", ifc.if_pc, 32'h0);
    chk("f1_Op", {25'b0, ifc.Op}, 32'h13);
    chk("f1_Funct3", {29'b0, ifc.Funct3}, 32'd0);
    cycle();
    chk("f1_next_req", {31'b0, ifc.imem_req}, 32'd1);
    chk("f1_next_addr", ifc.imem_addr, 32'h4);

    // stall in S_HOLD
    fixed_data = 32'h4010_5093;
    cycle();
    cycle();
    s_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("st_if_instr", ifc.if_instr, 32'h4010_5093);
      chk("st_Funct7", {25'b0, ifc.Funct7}, 32'h20);
      chk("st_Funct3", {29'b0, ifc.Funct3}, 32'h5);
      chk("st_if_valid", {31'b0, ifc.if_valid}, 32'd1);
      chk("st_no_req", {31'b0, ifc.imem_req}, 32'd0);
    end
    s_stall = 1'b0;
    cycle();
    chk("st_release_valid", {31'b0, ifc.if_valid}, 32'd0);
    chk("st_release_addr", ifc.imem_addr, 32'h8);

    // redirect while waiting on a 4-cycle memory
    mem_lat = 4; fixed_en = 1'b0;
    cycle();
    s_redir = 1'b1; s_rpc = 32'h0000_0103;
    cycle();
    s_redir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_if_valid", {31'b0, ifc.if_valid}, 32'd0);
    end
    chk("fl_req", {31'b0, ifc.imem_req}, 32'd1);
    chk("fl_addr", ifc.imem_addr, 32'h0000_0100);

    // redirect coincident with rvalid in S_WAIT
    mem_lat = 2;
    cycle();
    cycle();
    s_redir = 1'b1; s_rpc = 32'h0000_0200;
    cycle();
    s_redir = 1'b0;
    chk("wr_if_valid", {31'b0, ifc.if_valid}, 32'd0);
    chk("wr_addr", ifc.imem_addr, 32'h0000_0200);

    // redirect beats stall in S_HOLD
    mem_lat = 1;
    cycle();
    cycle();
    s_stall = 1'b1; s_redir = 1'b1; s_rpc = 32'h0000_0304;
    cycle();
    s_stall = 1'b0; s_redir = 1'b0;
    chk("hr_if_valid", {31'b0, ifc.if_valid}, 32'd0);
    chk("hr_if_instr", ifc.if_instr, NOP);
    chk("hr_addr", ifc.imem_addr, 32'h0000_0304);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (mem_cnt == 0) mem_lat = $urandom_range(1, 4);
      s_redir = ($urandom_range(0, 5) == 0);
      s_rpc   = $urandom;
      s_stall = $urandom_range(0, 1);
      cycle();
    end
    s_redir = 1'b0; s_stall = 1'b0;

    // reset while a fetch is in flight
    mem_lat = 3;
    guard = 0;
    while (!(m_pending && mem_cnt > 1) && guard < 20) begin
      cycle();
      guard++;
    end
    chk("rw_reach_wait", {31'b0, m_pending}, 32'd1);
    #2;
    reset = 1'b1;
    ifc.imem_rvalid = 1'b0;
    #1;
    chk("rw_if_valid", {31'b0, ifc.if_valid}, 32'd0);
    chk("rw_req", {31'b0, ifc.imem_req}, 32'd1);
    chk("rw_addr", ifc.imem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    stray_rv = 1'b1;
    for (int i = 0; i < 12; i++) cycle();

    // RESET_PC at the top of the address space wraps to 0
    @(negedge clk);
    rst1 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ifc1.imem_req) wrap_q.push_back(ifc1.imem_addr);
      r1 = ifc1.imem_req;
      @(negedge clk);
      ifc1.imem_rvalid = r1;
      ifc1.imem_rdata  = $urandom;
    end
    chk("wrap_nreq", {31'b0, (wrap_q.size() >= 2)}, 32'd1);
    if (wrap_q.size() >= 2) begin
      chk("wrap_first", wrap_q[0], 32'hFFFF_FFFC);
      chk("wrap_second", wrap_q[1], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
